// File: rtl/store_issue_gate_pkg.sv
// Shared build configuration, gate state encoding and region lookup.
package config_pkg;

  localparam int unsigned NrMaxRules = 4;

  typedef struct packed {
    int unsigned PLEN;
    int unsigned MaxOutstandingStores;
    int unsigned NrNonIdempotentRules;
    logic [NrMaxRules-1:0][63:0] NonIdempotentAddrBase;
    logic [NrMaxRules-1:0][63:0] NonIdempotentLength;
  } cva6_cfg_t;

  localparam cva6_cfg_t cva6_cfg_empty = '{
    PLEN: 34,
    MaxOutstandingStores: 7,
    NrNonIdempotentRules: 1,
    NonIdempotentAddrBase: {64'h0, 64'h0, 64'h0, 64'h1000_0000},
    NonIdempotentLength: {64'h0, 64'h0, 64'h0, 64'h1000}
  };

  typedef enum logic [1:0] {
    IDLE,
    NI_DRAIN,
    NI_WAIT,
    FENCE
  } store_gate_state_e;

  // One spare bit above PLEN keeps base+len from wrapping.
  function automatic logic is_inside_nonidempotent_regions(
    cva6_cfg_t cfg,
    logic [63:0] addr
  );
    logic [64:0] m;
    logic [64:0] a;
    logic [64:0] b;
    logic [64:0] e;
    logic hit;
    hit = 1'b0;
    m = (65'd1 << cfg.PLEN) - 65'd1;
    a = {1'b0, addr} & m;
    for (int unsigned i = 0; i < NrMaxRules; i++) begin
      b = {1'b0, cfg.NonIdempotentAddrBase[i]} & m;
      e = b + ({1'b0, cfg.NonIdempotentLength[i]} & m);
      if (i < cfg.NrNonIdempotentRules && a >= b && a < e)
        hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/store_issue_gate_counter.sv
// Up/down in-flight store counter with full/empty flags and
// a sticky flag for an acknowledge arriving with nothing in flight.
module store_gate_counter #(
  parameter int unsigned Max = 7,
  parameter int CntW = 3
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            inc_i,
  input  logic            dec_i,
  output logic [CntW-1:0] cnt_o,
  output logic            full_o,
  output logic            empty_o,
  output logic            err_o
);

  logic [CntW-1:0] r_cnt;
  logic            r_err;
  logic            w_zero;
  logic            w_full;
  logic            w_dec;
  logic            w_inc;

  assign w_zero = (r_cnt == '0);
  assign w_full = (r_cnt == CntW'(Max));
  assign w_dec  = dec_i & ~w_zero;
  assign w_inc  = inc_i & (~w_full | w_dec);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      r_cnt <= r_cnt + CntW'(w_inc) - CntW'(w_dec);
      if (dec_i & w_zero)
        r_err <= 1'b1;
    end
  end

  assign cnt_o   = r_cnt;
  assign full_o  = w_full;
  assign empty_o = w_zero;
  assign err_o   = r_err;

endmodule

// File: rtl/store_issue_gate.sv
// Store issue gate: caps in-flight stores, serializes non-idempotent
// stores, drains on fence. Optional STORE_GATE_PERF_EN adds stall_cnt_o.
module store_issue_gate
  import config_pkg::*;
#(
  parameter config_pkg::cva6_cfg_t CVA6Cfg = config_pkg::cva6_cfg_empty,
  parameter int CntW = $clog2(CVA6Cfg.MaxOutstandingStores + 1)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    st_valid_i,
  input  logic [CVA6Cfg.PLEN-1:0] st_paddr_i,
  output logic                    st_ready_o,
  output logic                    req_valid_o,
  input  logic                    req_ready_i,
  input  logic                    ack_i,
  input  logic                    fence_req_i,
  output logic                    fence_done_o,
  output logic [CntW-1:0]         outstanding_o,
  output logic                    empty_o,
  output logic                    err_o
`ifdef STORE_GATE_PERF_EN
  ,
  output logic [31:0]             stall_cnt_o
`endif
);

  store_gate_state_e r_state;
  store_gate_state_e w_state_nxt;

  logic [CntW-1:0] w_cnt;
  logic            w_full;
  logic            w_empty;
  logic            w_is_ni;
  logic            w_drained;
  logic            w_open;
  logic            w_hs;
  logic            w_done;

  assign w_is_ni = is_inside_nonidempotent_regions(
    CVA6Cfg, 64'(st_paddr_i));
  assign w_drained = w_empty | ((w_cnt == CntW'(1)) & ack_i);

  always_comb begin
    w_state_nxt = r_state;
    w_open      = 1'b0;
    w_done      = 1'b0;
    if (flush_i) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (fence_req_i) begin
            w_state_nxt = FENCE;
          end else if (st_valid_i & w_is_ni) begin
            if (w_empty) begin
              w_open = ~w_full;
              if (req_ready_i & w_open)
                w_state_nxt = NI_WAIT;
            end else begin
              w_state_nxt = NI_DRAIN;
            end
          end else begin
            w_open = ~w_full | ack_i;
          end
        end
        NI_DRAIN: begin
          w_open = w_drained;
          if (!st_valid_i)
            w_state_nxt = IDLE;
          else if (req_ready_i & w_open)
            w_state_nxt = NI_WAIT;
        end
        NI_WAIT: begin
          if (w_drained)
            w_state_nxt = IDLE;
        end
        FENCE: begin
          if (w_drained) begin
            w_done      = 1'b1;
            w_state_nxt = IDLE;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_state <= IDLE;
    else
      r_state <= w_state_nxt;
  end

  assign req_valid_o  = st_valid_i & w_open;
  assign st_ready_o   = req_ready_i & w_open;
  assign w_hs         = req_valid_o & req_ready_i;
  assign fence_done_o = w_done;

  store_gate_counter #(
    .Max (CVA6Cfg.MaxOutstandingStores),
    .CntW(CntW)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .inc_i  (w_hs),
    .dec_i  (ack_i),
    .cnt_o  (w_cnt),
    .full_o (w_full),
    .empty_o(w_empty),
    .err_o  (err_o)
  );

  assign outstanding_o = w_cnt;
  assign empty_o       = w_empty;

`ifdef STORE_GATE_PERF_EN
  logic [31:0] r_stall;

  always_ff @(posedge clk_i) begin
    if (rst_i)
      r_stall <= '0;
    else if (st_valid_i & ~st_ready_o & (r_stall != '1))
      r_stall <= r_stall + 32'd1;
  end

  assign stall_cnt_o = r_stall;
`endif

endmodule

// File: tb/tb_store_issue_gate.sv
// Bench for store_issue_gate: directed scenarios plus random traffic
// against a queue-free counter/mode reference model.
module tb_store_issue_gate;

  localparam config_pkg::cva6_cfg_t Cfg = '{
    PLEN: 34,
    MaxOutstandingStores: 7,
    NrNonIdempotentRules: 2,
    NonIdempotentAddrBase: {64'h0, 64'h0, 64'h2000_0000, 64'h1000_0000},
    NonIdempotentLength: {64'h0, 64'h0, 64'h0, 64'h1000}
  };
  localparam int MAXO = 7;
  localparam int CW = 3;

  logic clk_i = 0;
  logic rst_i = 1;
  logic flush_i = 0;
  logic st_valid_i = 0;
  logic [33:0] st_paddr_i = '0;
  logic st_ready_o;
  logic req_valid_o;
  logic req_ready_i = 1;
  logic ack_i = 0;
  logic fence_req_i = 0;
  logic fence_done_o;
  logic [CW-1:0] outstanding_o;
  logic empty_o;
  logic err_o;
`ifdef STORE_GATE_PERF_EN
  logic [31:0] stall_cnt_o;
`endif

  int total = 0;
  int bad = 0;

  store_issue_gate #(.CVA6Cfg(Cfg)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .st_valid_i(st_valid_i), .st_paddr_i(st_paddr_i),
    .st_ready_o(st_ready_o), .req_valid_o(req_valid_o),
    .req_ready_i(req_ready_i), .ack_i(ack_i),
    .fence_req_i(fence_req_i), .fence_done_o(fence_done_o),
    .outstanding_o(outstanding_o), .empty_o(empty_o), .err_o(err_o)
`ifdef STORE_GATE_PERF_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    st_valid_i = 0; ack_i = 0; flush_i = 0; fence_req_i = 0;
    req_ready_i = 1; rst_i = 1;
    tick(); tick();
    rst_i = 0;
  endtask

  task automatic issue(int n);
    st_valid_i = 1; req_ready_i = 1; st_paddr_i = 34'h0_8000_0000;
    for (int i = 0; i < n; i++) tick();
    st_valid_i = 0;
  endtask

  task automatic drain(int n);
    ack_i = 1;
    for (int i = 0; i < n; i++) tick();
    ack_i = 0;
  endtask

  task automatic test_reset();
    do_reset();
    st_valid_i = 1; st_paddr_i = 34'h0_8000_0000; req_ready_i = 1;
    #1;
    total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", outstanding_o); end
    total++; if (empty_o !== 1'b1) begin bad++; $display("FAIL rst_empty got=%b exp=1", empty_o); end
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL rst_err got=%b exp=0", err_o); end
    total++; if (fence_done_o !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", fence_done_o); end
    total++; if (st_ready_o !== 1'b1) begin bad++; $display("FAIL rst_ready got=%b exp=1", st_ready_o); end
    req_ready_i = 0; #1;
    total++; if (st_ready_o !== 1'b0) begin bad++; $display("FAIL rst_ready_gated got=%b exp=0", st_ready_o); end
    st_valid_i = 0; req_ready_i = 1;
  endtask

  task automatic test_back_to_back();
    int hs = 0;
    st_valid_i = 1; req_ready_i = 1; st_paddr_i = 34'h0_8000_0000;
    for (int i = 0; i < 8; i++) begin
      #1; if (st_ready_o && req_valid_o) hs++;
      tick();
    end
    #1;
    total++; if (hs !== 7) begin bad++; $display("FAIL b2b_hs got=%0d exp=7", hs); end
    total++; if (st_ready_o !== 1'b0) begin bad++; $display("FAIL b2b_full_ready got=%b exp=0", st_ready_o); end
    total++; if (outstanding_o !== 3'd7) begin bad++; $display("FAIL b2b_cnt got=%0d exp=7", outstanding_o); end
    ack_i = 1; #1;
    total++; if (st_ready_o !== 1'b1) begin bad++; $display("FAIL b2b_ack_reopen got=%b exp=1", st_ready_o); end
    tick();
    ack_i = 0; st_valid_i = 0; #1;
    total++; if (outstanding_o !== 3'd7) begin bad++; $display("FAIL b2b_cnt_after_ack got=%0d exp=7", outstanding_o); end
    drain(7); #1;
    total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL b2b_drained got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_ni();
    issue(3);
    st_valid_i = 1; st_paddr_i = 34'h0_1000_0010; #1;
    total++; if (st_ready_o !== 1'b0) begin bad++; $display("FAIL ni_closed got=%b exp=0", st_ready_o); end
    tick();
    ack_i = 1; #1;
    total++; if (st_ready_o !== 1'b0) begin bad++; $display("FAIL ni_drain1 got=%b exp=0", st_ready_o); end
    tick(); #1;
    total++; if (st_ready_o !== 1'b0) begin bad++; $display("FAIL ni_drain2 got=%b exp=0", st_ready_o); end
    tick(); #1;
    total++; if (st_ready_o !== 1'b1) begin bad++; $display("FAIL ni_issue got=%b exp=1", st_ready_o); end
    tick();
    ack_i = 0; st_paddr_i = 34'h0_8000_0000; #1;
    total++; if (st_ready_o !== 1'b0) begin bad++; $display("FAIL ni_wait_closed got=%b exp=0", st_ready_o); end
    total++; if (outstanding_o !== 3'd1) begin bad++; $display("FAIL ni_wait_cnt got=%0d exp=1", outstanding_o); end
    st_valid_i = 0; ack_i = 1; tick(); ack_i = 0;
    st_valid_i = 1; #1;
    total++; if (outstanding_o !== 3'd0) begin bad++; $display("FAIL ni_idle_cnt got=%0d exp=0", outstanding_o); end
    total++; if (st_ready_o !== 1'b1) begin bad++; $display("FAIL ni_idle_open got=%b exp=1", st_ready_o); end
    st_valid_i = 0;
  endtask

  task automatic test_fence();
    issue(2);
    fence_req_i = 1; st_valid_i = 1; #1;
    total++; if (fence_done_o !== 1'b0) begin bad++; $display("FAIL fence_c1 got=%b exp=0", fence_done_o); end
    tick(); #1;
    total++; if (fence_done_o !== 1'b0 || st_ready_o !== 1'b0) begin bad++; $display("FAIL fence_c2 done=%b rdy=%b exp=0,0", fence_done_o, st_ready_o); end
    tick(); st_valid_i = 0; ack_i = 1; #1;
    total++; if (fence_done_o !== 1'b0) begin bad++; $display("FAIL fence_ack1 got=%b exp=0", fence_done_o); end
    tick(); #1;
    total++; if (fence_done_o !== 1'b1) begin bad++; $display("FAIL fence_ack2 got=%b exp=1", fence_done_o); end
    tick(); ack_i = 0; #1;
    total++; if (fence_done_o !== 1'b0) begin bad++; $display("FAIL fence_pulse_width got=%b exp=0", fence_done_o); end
    tick(); #1;
    total++; if (fence_done_o !== 1'b1) begin bad++; $display("FAIL fence_reenter got=%b exp=1", fence_done_o); end
    fence_req_i = 0; tick(); #1;
    total++; if (fence_done_o !== 1'b0) begin bad++; $display("FAIL fence_released got=%b exp=0", fence_done_o); end
  endtask

  task automatic test_flush();
    issue(2);
    st_valid_i = 1; st_paddr_i = 34'h0_1000_0040; tick();
    flush_i = 1; #1;
    total++; if (st_ready_o !== 1'b0) begin bad++; $display("FAIL flush_cycle_closed got=%b exp=0", st_ready_o); end
    tick(); flush_i = 0; st_valid_i = 0; #1;
    total++; if (outstanding_o !== 3'd2) begin bad++; $display("FAIL flush_cnt got=%0d exp=2", outstanding_o); end
    st_valid_i = 1; st_paddr_i = 34'h0_8000_0000; #1;
    total++; if (st_ready_o !== 1'b1) begin bad++; $display("FAIL flush_idle got=%b exp=1", st_ready_o); end
    st_valid_i = 0;
    drain(2); #1;
    total++; if (outstanding_o !== 3'd0 || err_o !== 1'b0) begin bad++; $display("FAIL flush_drain cnt=%0d err=%b exp=0,0", outstanding_o, err_o); end
  endtask

  task automatic test_steady();
    issue(4);
    st_valid_i = 1; ack_i = 1;
    for (int i = 0; i < 10; i++) begin
      #1;
      total++; if (outstanding_o !== 3'd4 || st_ready_o !== 1'b1) begin bad++; $display("FAIL steady_%0d cnt=%0d rdy=%b exp=4,1", i, outstanding_o, st_ready_o); end
      tick();
    end
    st_valid_i = 0;
    drain(4);
  endtask

  task automatic test_err();
    do_reset();
    ack_i = 1; tick(); ack_i = 0; #1;
    total++; if (err_o !== 1'b1 || outstanding_o !== 3'd0) begin bad++; $display("FAIL err_set err=%b cnt=%0d exp=1,0", err_o, outstanding_o); end
    issue(2); drain(2); tick(); #1;
    total++; if (err_o !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", err_o); end
    do_reset(); #1;
    total++; if (err_o !== 1'b0) begin bad++; $display("FAIL err_cleared got=%b exp=0", err_o); end
  endtask

`ifdef STORE_GATE_PERF_EN
  task automatic test_perf();
    do_reset();
    st_valid_i = 1; req_ready_i = 0; st_paddr_i = 34'h0_8000_0000;
    for (int i = 0; i < 5; i++) tick();
    st_valid_i = 0; req_ready_i = 1; #1;
    total++; if (stall_cnt_o !== 32'd5) begin bad++; $display("FAIL perf_stall got=%0d exp=5", stall_cnt_o); end
  endtask
`endif

  function automatic bit ref_is_ni(longint unsigned a);
    return a >= 64'h1000_0000 && a < 64'h1000_0000 + 64'h1000;
  endfunction

  task automatic test_random();
    int mcnt = 0;
    int mode = 0;
    bit merr = 0;
    int nerr = 0;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      int sel;
      bit v, rdy, ak, fq, fl, ni, open, done, hs;
      int nxt, after;
      longint unsigned a;
      v = ($urandom_range(0, 9) < 7);
      rdy = ($urandom_range(0, 9) < 8);
      ak = (mcnt > 0) && ($urandom_range(0, 9) < 4);
      fq = ($urandom_range(0, 19) == 0);
      fl = ($urandom_range(0, 39) == 0);
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: a = 64'h1000_0000 + $urandom_range(0, 32'hfff);
        2: a = 64'h1000_1000;
        3: a = 64'h0fff_ffff;
        4: a = 64'h2000_0000;
        default: a = 64'h8000_0000 + $urandom_range(0, 32'hffff);
      endcase
      st_valid_i = v; req_ready_i = rdy; ack_i = ak;
      fence_req_i = fq; flush_i = fl; st_paddr_i = a[33:0];
      #1;
      ni = ref_is_ni(a);
      after = mcnt - int'(ak);
      open = 0; done = 0; nxt = mode;
      if (fl) nxt = 0;
      else case (mode)
        0: if (fq) nxt = 3;
           else if (v && ni) begin
             if (mcnt == 0) open = 1; else nxt = 1;
           end else open = (mcnt < MAXO) || ak;
        1: begin open = (after == 0); if (!v) nxt = 0; end
        2: if (after == 0) nxt = 0;
        default: if (after == 0) begin done = 1; nxt = 0; end
      endcase
      hs = v && open && rdy;
      if (hs && !fl && (mode == 1 || (mode == 0 && !fq && ni))) nxt = 2;
      if (st_ready_o !== (rdy && open) || req_valid_o !== (v && open)
          || fence_done_o !== done || outstanding_o !== CW'(mcnt)
          || empty_o !== (mcnt == 0) || err_o !== merr) begin
        nerr++;
        if (nerr <= 5) $display("FAIL rand_%0d rdy=%b/%b vld=%b/%b done=%b/%b cnt=%0d/%0d err=%b/%b",
          n, st_ready_o, rdy && open, req_valid_o, v && open, fence_done_o, done, outstanding_o, mcnt, err_o, merr);
      end
      mcnt = mcnt + int'(hs) - int'(ak);
      mode = nxt;
      tick();
    end
    total++; if (nerr !== 0) begin bad++; $display("FAIL rand_total got=%0d exp=0", nerr); end
    st_valid_i = 0; fence_req_i = 0; flush_i = 0;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_ni();
    test_fence();
    test_flush();
    test_steady();
    test_err();
`ifdef STORE_GATE_PERF_EN
    test_perf();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/store_issue_gate.md
Name: store_issue_gate

Overview:
- Sits between the store unit's commit-side store buffer and the data cache / memory request port.
- Limits the number of in-flight stores to the configured MaxOutstandingStores.
- Serializes stores to non-idempotent regions: drains all prior stores, issues the non-idempotent store alone, then waits for its acknowledge.
- Provides a fence drain handshake. Region rules and limits come from the CVA6 configuration.

Parameters:
- CVA6Cfg, config_pkg::cva6_cfg_empty: build configuration. Uses MaxOutstandingStores, NrNonIdempotentRules, NonIdempotentAddrBase, NonIdempotentLength and PLEN.
- CntW, $clog2(CVA6Cfg.MaxOutstandingStores+1): width of the outstanding counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  pipeline flush; aborts gate wait states; counter kept.
- st_valid_i  in  1  upstream store request valid.
- st_paddr_i  in  PLEN  physical address of the store.
- st_ready_o  out  1  upstream ready.
- req_valid_o  out  1  downstream request valid.
- req_ready_i  in  1  downstream ready.
- ack_i  in  1  one store completed (one pulse per store).
- fence_req_i  in  1  level request to drain all stores.
- fence_done_o  out  1  one-cycle pulse: drain complete.
- outstanding_o  out  CntW  current in-flight count.
- empty_o  out  1  outstanding_o == 0.
- err_o  out  1  sticky: ack_i received with count 0.

Behaviour:
- Reset (rst_i sampled high): FSM = IDLE, count = 0, err_o = 0, fence_done_o = 0. Therefore st_ready_o = req_ready_i gated, and empty_o = 1.
- Datapath is a zero-latency pass-through:
  - req_valid_o = st_valid_i & open.
  - st_ready_o = req_ready_i & open.
  - Handshake (hs) = req_valid_o & req_ready_i.
  - Address is not registered; the downstream block takes st_paddr_i directly.
- Counter:
  - +1 on hs, -1 on ack_i; both in the same cycle leaves it unchanged.
  - ack_i at count 0: counter stays 0 and err_o is set until reset.
  - Count never exceeds MaxOutstandingStores, because open is low while the counter is full.
- is_ni: st_paddr_i lies in [base_i, base_i+len_i) for any rule i < NrNonIdempotentRules. A rule with length 0 matches nothing. Arithmetic is done at PLEN+1 bits, so there is no wrap.
- FSM states and transitions:
  - IDLE, fence_req_i high (priority): open = 0, go to FENCE.
  - IDLE, no fence, st_valid_i & is_ni:
    - Count == 0: open = ~full; on hs go to NI_WAIT.
    - Count != 0: open = 0, go to NI_DRAIN.
  - IDLE otherwise: open = (count < Max), plus same-cycle ack_i counted, so a full counter with ack_i reopens the gate in that cycle.
  - NI_DRAIN: open = (count == 0 after this cycle's ack, i.e. count==0 | (count==1 & ack_i)); on hs go to NI_WAIT.
  - NI_WAIT: open = 0; when the count reaches 0 (ack_i with count 1), go to IDLE in the next cycle.
  - FENCE: open = 0. When count == 0 (or count == 1 with ack_i), pulse fence_done_o in that cycle and go to IDLE. If fence_req_i is still high the following cycle, the FSM re-enters FENCE and completes immediately when empty.
- flush_i:
  - Forces NI_DRAIN, NI_WAIT or FENCE back to IDLE in the next cycle, with open = 0 during the flush cycle.
  - In-flight stores are already committed; the counter still tracks their acks.
  - A flush during FENCE produces no fence_done_o.
- A store dropping st_valid_i while in NI_DRAIN (not legal upstream) returns the FSM to IDLE.

Optional Feature:
- Macro STORE_GATE_PERF_EN.
- When defined: adds output stall_cnt_o [31:0], a saturating count of cycles with st_valid_i & ~st_ready_o. It resets to 0 and is cleared by neither flush_i nor a fence.
- When undefined: the port and counter are absent; everything else is identical.

Decomposition:
- config_pkg (shared package):
  - gate state enum store_gate_state_e {IDLE, NI_DRAIN, NI_WAIT, FENCE}.
  - function is_inside_nonidempotent_regions(cfg, addr).
- One sub-module, store_gate_counter: up/down saturating counter with full/empty flags and error detect.
- The FSM stays in store_issue_gate.

Test Plan:
- Max = 7, req_ready_i = 1, 8 back-to-back cacheable stores at 0x8000_0000, no ack → 7 handshakes; then st_ready_o = 0 and outstanding_o = 7. Assert ack_i once → 8th store issues in the same cycle, count stays 7.
- Rule 0 = base 0x1000_0000, len 0x1000. Count = 3, store to 0x1000_0010 → NI_DRAIN, gate closed. 3 acks → store issues, NI_WAIT. Ack → IDLE, count 0.
- Count = 2, fence_req_i held high → fence_done_o low until the 2nd ack; pulses exactly 1 cycle in that ack cycle.
- ack_i with count 0 after reset → err_o = 1 and stays 1. outstanding_o = 0.
- In NI_DRAIN with count 2, pulse flush_i → IDLE in the next cycle; outstanding_o still 2; two later acks bring it to 0, err_o = 0.
- Simultaneous hs and ack_i at count 4 for 10 cycles → outstanding_o constant at 4. With STORE_GATE_PERF_EN: hold st_valid_i with req_ready_i = 0 for 5 cycles → stall_cnt_o = 5.
